bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares the single-port 16-bit program/data BRAM between two requesters.
  - Port 0: CPU memory controller.
  - Port 1: loader/debug port (e.g. UART program loader).
- Fixed priority to the CPU, with a starvation guard for the loader.
- Pipelined read-return routing: each read's data goes back to the port that issued it.
- Sits between the requesters and the BRAM primitive. It is the only block that drives the BRAM port.

Parameters:
- BRAM_LAT, 1, BRAM read latency in clocks from sampled address to valid douta (1..4).
- MAX_WAIT, 8, consecutive cycles port 1 may be denied before it wins arbitration (1..255).
- ADDR_W, 16, address width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-low reset (low = reset, sampled on posedge clk).
- p0_req  input  1  CPU access request; held with p0_we/p0_addr/p0_wdata until granted.
- p0_we  input  1  CPU write enable (1 = write, 0 = read).
- p0_addr  input  ADDR_W  CPU address.
- p0_wdata  input  16  CPU write data.
- p0_gnt  output  1  combinational; request accepted at this clock edge.
- p0_rvalid  output  1  one-cycle read data valid.
- p0_rdata  output  16  read data, held until next p0_rvalid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for the loader.
- p1_lock  input  1  bus lock request (used only with ARB_LOCK_EN).
- cpu_stall  output  1  high while port 1 holds the lock (0 when feature absent).
- bram_wea  output  1  registered BRAM write enable.
- bram_addra  output  ADDR_W  registered BRAM address.
- bram_dina  output  16  registered BRAM write data.
- bram_douta  input  16  BRAM read data.

Behaviour:
- Reset (rst == 0 at posedge):
  - Outputs cleared: bram_wea, bram_addra, bram_dina, all rvalid/rdata, cpu_stall.
  - State cleared: wait_cnt = 0, state = ARB, read-tracking pipeline flushed.
  - Reads in flight at reset never produce rvalid.
- Gnt is combinational from the req inputs and state. At most one gnt is high per cycle.
- Arbitration in ARB state:
  - If only one port requests, it is granted.
  - If both request: port 1 wins when wait_cnt >= MAX_WAIT; otherwise port 0 wins.
- wait_cnt:
  - Increments when p1_req && !p1_gnt; saturates at 255.
  - Clears when p1_gnt, or when p1_req is low.
- Issue: on a granted edge, bram_addra/bram_wea/bram_dina register the winner's addr/we/wdata.
  - Cycles with no grant: bram_wea = 0, bram_addra/bram_dina hold their previous values.
- Read tracking:
  - A granted read pushes {valid, port} into a BRAM_LAT+1 deep shift register.
  - When an entry exits, bram_douta is registered into that port's rdata and its rvalid pulses for 1 cycle.
  - Read latency: rvalid is high in the cycle after edge E+BRAM_LAT+1, where E is the grant edge (default: 2 edges).
  - Back-to-back reads, including reads alternating between ports, sustain 1 access/cycle with in-order return.
- Writes produce no rvalid. A read issued the cycle after a write to the same address returns the new data (BRAM write-first mode required).
- rdata holds its value between rvalid pulses.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With ARB_LOCK_EN:
  - ARB -> LOCKED when port 1 is granted with p1_lock = 1.
  - In LOCKED: p0_gnt forced 0, cpu_stall = 1, port 1 granted on every p1_req.
  - LOCKED -> ARB on the first edge with p1_lock = 0; cpu_stall drops the same cycle.
  - CPU reads already in flight on lock entry still return normally.
- Without ARB_LOCK_EN: p1_lock ignored, cpu_stall tied 0, state machine is ARB only.

Test Plan:
- Reset: hold rst = 0 with p0_req = 1 -> no gnt, bram_wea = 0, bram_addra = 0, no rvalid; release -> p0 granted on the first edge.
- Single read: BRAM preloaded mem[0x0010] = 0xBEEF, p0 read 0x0010 -> p0_rvalid exactly 2 edges after grant, p0_rdata = 0xBEEF, p1_rvalid stays 0.
- Write then read: p1 write 0x0020 = 0x1234, next cycle p1 read 0x0020 -> bram_wea pulse 1 cycle, p1_rdata = 0x1234.
- Starvation: p0_req and p1_req held high continuously -> p1 granted on the 9th cycle (MAX_WAIT = 8), then p0 resumes.
- Interleave: alternating p0/p1 reads of 0x0001..0x0004 -> each rdata routed to its issuing port, in order, one access per cycle.
- Lock (ARB_LOCK_EN): p1 read with lock = 1, then p0_req = 1 for 5 cycles -> p0_gnt = 0 and cpu_stall = 1 throughout; lock = 0 -> p0 granted the next cycle.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-port arbiter for the shared single-port 16-bit program/data BRAM: CPU priority,
// loader starvation guard, and per-port read-return routing. Optional bus lock: ARB_LOCK_EN.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   ARB    | normal arbitration, CPU first unless the loader is starved
//   LOCKED | loader owns the BRAM, CPU stalled (only with ARB_LOCK_EN)
module bram_port_arbiter #(
    parameter int BRAM_LAT = 1,
    parameter int MAX_WAIT = 8,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [15:0]       p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [15:0]       p1_rdata,

    input  logic              p1_lock,
    output logic              cpu_stall,

    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [15:0]       bram_dina,
    input  logic [15:0]       bram_douta
);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic        starved;
    logic        rd_issue;

    // Read-tracking pipeline: bit 0 is the grant edge, bit BRAM_LAT lines up with douta.
    logic [BRAM_LAT:0] rd_vld;
    logic [BRAM_LAT:0] rd_port;

    assign starved  = (wait_cnt >= 8'(MAX_WAIT));
    assign rd_issue = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);

`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = p1_lock;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef ARB_LOCK_EN
        case (state)
            ARB:     if (p1_gnt && p1_lock) state_nxt = LOCKED;
            LOCKED:  if (!p1_lock)          state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
`else
        state_nxt = ARB;
`endif
    end

    // Grants are gated by reset so nothing is accepted while rst is low.
    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        cpu_stall = 1'b0;
        if (rst) begin
            case (state)
                ARB: begin
                    if (p1_req && (!p0_req || starved)) begin
                        p1_gnt = 1'b1;
                    end else if (p0_req) begin
                        p0_gnt = 1'b1;
                    end
                end
`ifdef ARB_LOCK_EN
                LOCKED: begin
                    p1_gnt    = p1_req;
                    cpu_stall = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (!p1_req || p1_gnt) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= 16'd0;
        end else if (p1_gnt) begin
            bram_wea   <= p1_we;
            bram_addra <= p1_addr;
            bram_dina  <= p1_wdata;
        end else if (p0_gnt) begin
            bram_wea   <= p0_we;
            bram_addra <= p0_addr;
            bram_dina  <= p0_wdata;
        end else begin
            bram_wea   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_vld  <= '0;
            rd_port <= '0;
        end else begin
            rd_vld  <= {rd_vld[BRAM_LAT-1:0], rd_issue};
            rd_port <= {rd_port[BRAM_LAT-1:0], p1_gnt};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= 16'd0;
            p1_rdata  <= 16'd0;
        end else begin
            p0_rvalid <= rd_vld[BRAM_LAT] && !rd_port[BRAM_LAT];
            p1_rvalid <= rd_vld[BRAM_LAT] &&  rd_port[BRAM_LAT];
            if (rd_vld[BRAM_LAT] && !rd_port[BRAM_LAT]) begin
                p0_rdata <= bram_douta;
            end
            if (rd_vld[BRAM_LAT] && rd_port[BRAM_LAT]) begin
                p1_rdata <= bram_douta;
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a write-first, one-cycle BRAM model.
// Lock scenario is compiled in only when ARB_LOCK_EN is defined.
module tb_bram_port_arbiter;

    localparam int LAT = 1;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [15:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [15:0] p1_addr, p1_wdata, p1_rdata;
    logic        p1_lock, cpu_stall;
    logic        bram_wea;
    logic [15:0] bram_addra, bram_dina, bram_douta;

    logic [15:0] mem [0:65535];

    typedef struct {
        bit          port;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bram_port_arbiter #(.BRAM_LAT(LAT), .MAX_WAIT(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_lock(p1_lock), .cpu_stall(cpu_stall),
        .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_douta(bram_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first BRAM: a write returns the new data on douta.
    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dina;
        bram_douta <= bram_wea ? bram_dina : mem[bram_addra];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && (p0_rvalid || p1_rvalid)) begin
            exp_t e;
            chk("rvalid_onehot", {31'd0, p0_rvalid & p1_rvalid}, 32'd0);
            if (q.size() == 0) begin
                chk("rvalid_unexpected", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("ret_port", {31'd0, p1_rvalid}, {31'd0, e.port});
                chk("ret_data", {16'd0, (p1_rvalid ? p1_rdata : p0_rdata)}, {16'd0, e.data});
                chk("ret_cycle", cyc, e.cyc);
            end
        end
    end

    // Drives one request for one cycle; it must be granted immediately.
    task automatic access(input bit port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_rd, input string name);
        if (port == 1'b0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; p1_req = 1'b0;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; p0_req = 1'b0;
        end
        @(negedge clk);
        chk({name, "_gnt0"}, {31'd0, p0_gnt}, {31'd0, !port});
        chk({name, "_gnt1"}, {31'd0, p1_gnt}, {31'd0, port});
        if (!we) q.push_back('{port, exp_rd, cyc + LAT + 2});
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic idle(input int n);
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0001] = 16'hA001;
        mem[16'h0002] = 16'hA002;
        mem[16'h0003] = 16'hA003;
        mem[16'h0004] = 16'hA004;
        rst = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010; p0_wdata = 16'h0000;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0000; p1_wdata = 16'h0000;
        p1_lock = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", {31'd0, p0_gnt}, 32'd0);
        chk("rst_gnt1", {31'd0, p1_gnt}, 32'd0);
        chk("rst_wea", {31'd0, bram_wea}, 32'd0);
        chk("rst_addra", {16'd0, bram_addra}, 32'd0);
        chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "single_rd");
        chk("single_addra", {16'd0, bram_addra}, 32'h0010);
        idle(4);
        chk("rdata_hold", {16'd0, p0_rdata}, 32'hBEEF);
        chk("rvalid_low", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);

        access(1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, "p1_wr");
        chk("wr_wea", {31'd0, bram_wea}, 32'd1);
        chk("wr_addra", {16'd0, bram_addra}, 32'h0020);
        chk("wr_dina", {16'd0, bram_dina}, 32'h1234);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, "p1_rd");
        chk("wr_wea_pulse", {31'd0, bram_wea}, 32'd0);
        idle(4);

        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0100; p0_wdata = 16'h5555;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0200; p1_wdata = 16'hAAAA;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("starve_gnt0_c%0d", i), {31'd0, p0_gnt}, {31'd0, i != 9});
            chk($sformatf("starve_gnt1_c%0d", i), {31'd0, p1_gnt}, {31'd0, i == 9});
            @(posedge clk); #1;
            if (i == 9) chk("starve_addra", {16'd0, bram_addra}, 32'h0200);
        end
        idle(2);

        access(1'b0, 1'b0, 16'h0001, 16'h0000, 16'hA001, "il_1");
        access(1'b1, 1'b0, 16'h0002, 16'h0000, 16'hA002, "il_2");
        access(1'b0, 1'b0, 16'h0003, 16'h0000, 16'hA003, "il_3");
        access(1'b1, 1'b0, 16'h0004, 16'h0000, 16'hA004, "il_4");
        idle(5);

`ifdef ARB_LOCK_EN
        p1_lock = 1'b1;
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "lock_rd");
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0300; p0_wdata = 16'h0F0F;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("lock_gnt0_c%0d", i), {31'd0, p0_gnt}, 32'd0);
            chk($sformatf("lock_stall_c%0d", i), {31'd0, cpu_stall}, 32'd1);
            @(posedge clk); #1;
        end
        p1_lock = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("unlock_gnt0", {31'd0, p0_gnt}, 32'd1);
        chk("unlock_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        idle(5);
`endif

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
